// File: rtl/pakin_io.sv
// pakin_io -- receive end of the 4-phase req/ack packet channel.
//
// The packet source runs on an unrelated clock. Its req is brought into the
// i_clk domain through a two-flop synchroniser. The src/dst/dat/red buses are
// bundled with req and stay stable while req is high, so they are sampled
// directly. Each captured packet is checked for destination sequence, address
// range and redundancy value. It is then pushed, errors and all, into a small
// FIFO for local consumers.
//
// Ports:
//   i_clk, reset        sole clock; asynchronous active-high reset
//   i0_req              channel request (asynchronous to i_clk)
//   i0_src/dst/dat/red  packet fields, bundled with i0_req
//   i0_ack              channel acknowledge (registered)
//   o_rdy               FIFO not empty
//   o_src/dst/dat       FIFO head (zero while empty)
//   i_pop               consume FIFO head; ignored while o_rdy=0
//   o_pkt_cnt           accepted packets, wraps
//   o_err_cnt           packets with any error, saturates at 255
//   o_err_flags         sticky {seq, addr, red} error bits
//   o_leds              low nibble of the last accepted data word

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakin_io #(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int ASZ      = `NS_ADDRESS_SIZE,
    parameter int DSZ      = `NS_DATA_SIZE,
    parameter int RSZ      = `NS_REDUN_SIZE,
    parameter int EXP_RED  = 15,
    parameter int FLOG2    = 2
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic           i0_req,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    output logic           i0_ack,
    output logic           o_rdy,
    output logic [ASZ-1:0] o_src,
    output logic [ASZ-1:0] o_dst,
    output logic [DSZ-1:0] o_dat,
    input  logic           i_pop,
    output logic [15:0]    o_pkt_cnt,
    output logic [7:0]     o_err_cnt,
    output logic [2:0]     o_err_flags,
    output logic [3:0]     o_leds
);

    localparam int DEPTH = 1 << FLOG2;
    localparam int PW    = 2 * ASZ + DSZ;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    // Successor in the destination sequence, wrapping MAX_ADDR -> MIN_ADDR.
    function automatic logic [ASZ-1:0] nxt_addr(input logic [ASZ-1:0] a);
        if (a >= ASZ'(MAX_ADDR)) begin
            return ASZ'(MIN_ADDR);
        end else begin
            return a + ASZ'(1);
        end
    endfunction

    state_t         state_r, state_nxt_s;
    logic           req_meta_r, req_s;
    logic           ack_r, ack_nxt_s, capture_s;
    logic [PW-1:0]  mem_r [DEPTH];
    logic [FLOG2:0] wr_ptr_r, rd_ptr_r;
    logic           full_s, empty_s, pop_s;
    logic           seq_err_s, addr_err_s, red_err_s, any_err_s;
    logic           first_r;
    logic [ASZ-1:0] last_dst_r;
    logic [15:0]    pkt_cnt_r;
    logic [7:0]     err_cnt_r;
    logic [2:0]     flags_r;
    logic [3:0]     leds_r;

    // Two-flop synchroniser for the asynchronous request.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            req_meta_r <= 1'b0;
            req_s      <= 1'b0;
        end else begin
            req_meta_r <= i0_req;
            req_s      <= req_meta_r;
        end
    end

    // Handshake state and acknowledge register.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= ack_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_s && !full_s) begin
                    state_nxt_s = S_ACK;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_ACK;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM outputs: capture strobe and next acknowledge value.
    always_comb begin
        capture_s = 1'b0;
        ack_nxt_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_s && !full_s) begin
                    capture_s = 1'b1;
                    ack_nxt_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                    ack_nxt_s = 1'b0;
                end
            end
            S_ACK: begin
                capture_s = 1'b0;
                ack_nxt_s = req_s;
            end
            default: begin
                capture_s = 1'b0;
                ack_nxt_s = 1'b0;
            end
        endcase
    end

    // Full/empty come from registered pointers, so a pop in the same cycle
    // cannot unblock a capture until the next edge.
    assign full_s  = (wr_ptr_r[FLOG2] != rd_ptr_r[FLOG2]) &&
                     (wr_ptr_r[FLOG2-1:0] == rd_ptr_r[FLOG2-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign pop_s   = i_pop && !empty_s;

    // FIFO pointers.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(FLOG2+1){1'b0}};
            rd_ptr_r <= {(FLOG2+1){1'b0}};
        end else begin
            if (capture_s) begin
                wr_ptr_r <= wr_ptr_r + {{FLOG2{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{FLOG2{1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage; contents are masked at the outputs while empty.
    always_ff @(posedge i_clk) begin
        if (capture_s) begin
            mem_r[wr_ptr_r[FLOG2-1:0]] <= {i0_src, i0_dst, i0_dat};
        end
    end

    // Packet checks, evaluated against the bundled buses at capture.
    assign addr_err_s = (i0_dst < ASZ'(MIN_ADDR)) || (i0_dst > ASZ'(MAX_ADDR));
    assign red_err_s  = (i0_red != RSZ'(EXP_RED));
    assign seq_err_s  = !first_r && (i0_dst != nxt_addr(last_dst_r));
    assign any_err_s  = seq_err_s || addr_err_s || red_err_s;

    // Sequence tracking, counters, sticky flags and LEDs.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            first_r    <= 1'b1;
            last_dst_r <= {ASZ{1'b0}};
            pkt_cnt_r  <= 16'd0;
            err_cnt_r  <= 8'd0;
            flags_r    <= 3'b000;
            leds_r     <= 4'h0;
        end else if (capture_s) begin
            first_r    <= 1'b0;
            last_dst_r <= i0_dst;
            pkt_cnt_r  <= pkt_cnt_r + 16'd1;
            if (any_err_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            flags_r <= flags_r | {seq_err_s, addr_err_s, red_err_s};
            leds_r  <= i0_dat[3:0];
        end
    end

    assign i0_ack      = ack_r;
    assign o_rdy       = !empty_s;
    assign {o_src, o_dst, o_dat} = empty_s ? {PW{1'b0}} : mem_r[rd_ptr_r[FLOG2-1:0]];
    assign o_pkt_cnt   = pkt_cnt_r;
    assign o_err_cnt   = err_cnt_r;
    assign o_err_flags = flags_r;
    assign o_leds      = leds_r;

endmodule

// File: tb/tb_pakin_io.sv
module tb_pakin_io;

    localparam int MINA = 1;
    localparam int MAXA = 3;
    localparam int ERED = 15;

    logic        i_clk = 1'b0;
    logic        reset = 1'b1;
    logic        i0_req = 1'b0;
    logic [7:0]  i0_src = 8'd0, i0_dst = 8'd0, i0_dat = 8'd0;
    logic [3:0]  i0_red = 4'd0;
    logic        i0_ack, o_rdy, i_pop = 1'b0;
    logic [7:0]  o_src, o_dst, o_dat;
    logic [15:0] o_pkt_cnt;
    logic [7:0]  o_err_cnt;
    logic [2:0]  o_err_flags;
    logic [3:0]  o_leds;

    pakin_io #(.MIN_ADDR(MINA), .MAX_ADDR(MAXA), .ASZ(8), .DSZ(8), .RSZ(4),
               .EXP_RED(ERED), .FLOG2(2)) dut (
        .i_clk(i_clk), .reset(reset), .i0_req(i0_req), .i0_src(i0_src),
        .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red), .i0_ack(i0_ack),
        .o_rdy(o_rdy), .o_src(o_src), .o_dst(o_dst), .o_dat(o_dat),
        .i_pop(i_pop), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt),
        .o_err_flags(o_err_flags), .o_leds(o_leds));

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queue of packets plus counters.
    typedef struct packed { logic [7:0] src; logic [7:0] dst; logic [7:0] dat; } pkt_t;
    pkt_t       q[$];
    int         m_pkt, m_err;
    logic [2:0] m_flags;
    logic [3:0] m_leds;
    bit         m_first;
    logic [7:0] m_last;

    function automatic logic [7:0] nxt(input logic [7:0] a);
        return (int'(a) >= MAXA) ? 8'(MINA) : a + 8'd1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pkt = 0; m_err = 0; m_flags = 3'b000; m_leds = 4'h0;
        m_first = 1'b1; m_last = 8'd0;
    endtask

    task automatic model_capture(input logic [7:0] s, input logic [7:0] d,
                                 input logic [7:0] t, input logic [3:0] r);
        bit es, ea, er;
        pkt_t p;
        ea = (int'(d) < MINA) || (int'(d) > MAXA);
        er = (int'(r) != ERED);
        es = !m_first && (d != nxt(m_last));
        m_pkt = (m_pkt + 1) % 65536;
        if (es || ea || er) m_err = (m_err < 255) ? m_err + 1 : 255;
        m_flags = m_flags | {es, ea, er};
        m_leds = t[3:0];
        m_first = 1'b0;
        m_last = d;
        p.src = s; p.dst = d; p.dat = t;
        q.push_back(p);
    endtask

    // Stimulus helpers (no checking inside).
    task automatic do_reset();
        @(negedge i_clk);
        reset = 1'b1; i0_req = 1'b0; i_pop = 1'b0;
        repeat (2) @(negedge i_clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic raise_req(input logic [7:0] s, input logic [7:0] d,
                             input logic [7:0] t, input logic [3:0] r, output int lat);
        @(negedge i_clk);
        i0_src = s; i0_dst = d; i0_dat = t; i0_red = r; i0_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge i_clk);
            if (i0_ack === 1'b1) begin lat = i; break; end
        end
        if (lat > 0) model_capture(s, d, t, r);
    endtask

    task automatic drop_req(output int lat);
        i0_req = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge i_clk);
            if (i0_ack === 1'b0) begin lat = i; break; end
        end
    endtask

    task automatic pop_one();
        i_pop = 1'b1;
        @(negedge i_clk);
        i_pop = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (i0_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", i0_ack); end
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0", o_rdy); end
        n_checks++; if ({o_src, o_dst, o_dat} !== 24'd0) begin n_fail++; $display("FAIL reset_head got=%h exp=0", {o_src, o_dst, o_dat}); end
        n_checks++; if (o_pkt_cnt !== 16'd0 || o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_pkt_cnt, o_err_cnt); end
        n_checks++; if (o_err_flags !== 3'b000 || o_leds !== 4'h0) begin n_fail++; $display("FAIL reset_flags_leds got=%b/%h exp=000/0", o_err_flags, o_leds); end
    endtask

    task automatic test_single();
        int lr, lf;
        do_reset();
        raise_req(8'd3, 8'd1, 8'd5, 4'd15, lr);
        drop_req(lf);
        n_checks++; if (lr !== 3) begin n_fail++; $display("FAIL single_ack_rise_lat got=%0d exp=3", lr); end
        n_checks++; if (lf !== 3) begin n_fail++; $display("FAIL single_ack_fall_lat got=%0d exp=3", lf); end
        n_checks++; if (o_rdy !== 1'b1 || o_dat !== 8'd5 || o_src !== 8'd3 || o_dst !== 8'd1) begin
            n_fail++; $display("FAIL single_head got rdy=%b src=%0d dst=%0d dat=%0d exp 1/3/1/5", o_rdy, o_src, o_dst, o_dat); end
        n_checks++; if (o_pkt_cnt !== 16'd1 || o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL single_cnt got=%0d/%0d exp=1/0", o_pkt_cnt, o_err_cnt); end
        n_checks++; if (o_leds !== 4'd5) begin n_fail++; $display("FAIL single_leds got=%h exp=5", o_leds); end
    endtask

    task automatic test_seq();
        logic [7:0] dsts [5];
        int exp_err [5];
        int lr, lf;
        dsts = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd3};
        exp_err = '{0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            raise_req(8'(i), dsts[i], 8'($urandom_range(0, 255)), 4'd15, lr);
            drop_req(lf);
            n_checks++; if (lr <= 0 || lf <= 0) begin n_fail++; $display("FAIL seq_handshake[%0d] got rise=%0d fall=%0d exp >0", i, lr, lf); end
            n_checks++; if (o_err_cnt !== 8'(exp_err[i])) begin n_fail++; $display("FAIL seq_err_cnt[%0d] got=%0d exp=%0d", i, o_err_cnt, exp_err[i]); end
            pop_one();
        end
        n_checks++; if (o_err_flags !== 3'b100) begin n_fail++; $display("FAIL seq_flags got=%b exp=100", o_err_flags); end
        n_checks++; if (o_pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL seq_pkt_cnt got=%0d exp=5", o_pkt_cnt); end
    endtask

    task automatic test_errors();
        int lr, lf;
        do_reset();
        raise_req(8'd2, 8'd9, 8'hA6, 4'd7, lr);
        drop_req(lf);
        n_checks++; if (o_err_flags !== 3'b011) begin n_fail++; $display("FAIL err_flags got=%b exp=011", o_err_flags); end
        n_checks++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt got=%0d exp=1", o_err_cnt); end
        n_checks++; if (o_rdy !== 1'b1 || o_dst !== 8'd9 || o_dat !== 8'hA6) begin
            n_fail++; $display("FAIL err_pkt_kept got rdy=%b dst=%0d dat=%h exp 1/9/a6", o_rdy, o_dst, o_dat); end
    endtask

    task automatic drain_compare(input string tag);
        int n;
        n = 0;
        while (q.size() > 0 && n < 8) begin
            n_checks++; if (o_rdy !== 1'b1 || o_src !== q[0].src || o_dst !== q[0].dst || o_dat !== q[0].dat) begin
                n_fail++; $display("FAIL %s_head[%0d] got rdy=%b %h/%h/%h exp 1 %h/%h/%h", tag, n, o_rdy, o_src, o_dst, o_dat, q[0].src, q[0].dst, q[0].dat); end
            pop_one();
            n++;
        end
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL %s_empty got rdy=%b exp=0", tag, o_rdy); end
    endtask

    task automatic fill_four();
        int lr, lf;
        for (int i = 0; i < 4; i++) begin
            raise_req(8'(16 + i), 8'(1 + (i % 3)), 8'(32 + i), 4'd15, lr);
            drop_req(lf);
            n_checks++; if (lr !== 3) begin n_fail++; $display("FAIL fill_lat[%0d] got=%0d exp=3", i, lr); end
        end
    endtask

    task automatic test_backpressure();
        int lr, lf;
        bit seen;
        do_reset();
        fill_four();
        i0_src = 8'd20; i0_dst = 8'd2; i0_dat = 8'd36; i0_red = 4'd15; i0_req = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge i_clk); if (i0_ack !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL bp_ack_while_full got=1 exp=0"); end
        n_checks++; if (o_pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_pkt_cnt got=%0d exp=4", o_pkt_cnt); end
        pop_one();
        lr = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i0_ack === 1'b1) begin lr = i; break; end
            @(negedge i_clk);
        end
        n_checks++; if (lr <= 0) begin n_fail++; $display("FAIL bp_ack_after_pop got=timeout exp=ack"); end
        else model_capture(8'd20, 8'd2, 8'd36, 4'd15);
        drop_req(lf);
        n_checks++; if (o_pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_pkt_cnt5 got=%0d exp=5", o_pkt_cnt); end
        drain_compare("bp");
    endtask

    task automatic test_full_pop_same_cycle();
        int lf;
        do_reset();
        fill_four();
        i0_src = 8'd77; i0_dst = 8'd2; i0_dat = 8'd99; i0_red = 4'd15; i0_req = 1'b1;
        repeat (5) @(negedge i_clk);
        i_pop = 1'b1;
        @(negedge i_clk);
        i_pop = 1'b0;
        void'(q.pop_front());
        n_checks++; if (i0_ack !== 1'b0) begin n_fail++; $display("FAIL fps_no_capture_on_pop got=%b exp=0", i0_ack); end
        @(negedge i_clk);
        n_checks++; if (i0_ack !== 1'b1) begin n_fail++; $display("FAIL fps_capture_next got=%b exp=1", i0_ack); end
        model_capture(8'd77, 8'd2, 8'd99, 4'd15);
        drop_req(lf);
        drain_compare("fps");
    endtask

    task automatic test_reset_mid();
        int lr, lf;
        do_reset();
        raise_req(8'd4, 8'd1, 8'd7, 4'd15, lr);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (i0_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_async got=%b exp=0", i0_ack); end
        n_checks++; if (o_pkt_cnt !== 16'd0 || o_rdy !== 1'b0) begin n_fail++; $display("FAIL rmid_clear got cnt=%0d rdy=%b exp 0/0", o_pkt_cnt, o_rdy); end
        model_reset();
        repeat (2) @(negedge i_clk);
        reset = 1'b0;
        lr = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            if (i0_ack === 1'b1) begin lr = i; break; end
        end
        n_checks++; if (lr !== 3) begin n_fail++; $display("FAIL rmid_recapture_lat got=%0d exp=3", lr); end
        if (lr > 0) model_capture(8'd4, 8'd1, 8'd7, 4'd15);
        n_checks++; if (o_pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_pkt_cnt got=%0d exp=1", o_pkt_cnt); end
        drop_req(lf);
    endtask

    task automatic test_random();
        int lr, lf;
        logic [7:0] d;
        logic [3:0] r;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if (q.size() == 4 || (q.size() > 0 && $urandom_range(0, 2) == 0)) pop_one();
            if (m_first || $urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 5));
            else d = nxt(m_last);
            r = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'd15;
            raise_req(8'($urandom_range(0, 255)), d, 8'($urandom_range(0, 255)), r, lr);
            drop_req(lf);
            n_checks++; if (lr <= 0 || lf <= 0) begin n_fail++; $display("FAIL rnd_handshake[%0d] got rise=%0d fall=%0d exp >0", it, lr, lf); end
            n_checks++; if (o_pkt_cnt !== 16'(m_pkt) || o_err_cnt !== 8'(m_err)) begin
                n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", it, o_pkt_cnt, o_err_cnt, m_pkt, m_err); end
            n_checks++; if (o_err_flags !== m_flags || o_leds !== m_leds) begin
                n_fail++; $display("FAIL rnd_flags_leds[%0d] got=%b/%h exp=%b/%h", it, o_err_flags, o_leds, m_flags, m_leds); end
            n_checks++; if (o_rdy !== 1'b1 || o_src !== q[0].src || o_dst !== q[0].dst || o_dat !== q[0].dat) begin
                n_fail++; $display("FAIL rnd_head[%0d] got %h/%h/%h exp %h/%h/%h", it, o_src, o_dst, o_dat, q[0].src, q[0].dst, q[0].dat); end
        end
        drain_compare("rnd");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_seq();
        test_errors();
        test_backpressure();
        test_full_pop_same_cycle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
